alu_scheduler: RTL and testbench

Sequencer and arbiter that shares the single combinational 32-bit ALU among NREQ requesters (e.g. issue stage and address-generation unit). It accepts one operation at a time over a valid/ready handshake, drives the ALU operand/control inputs from registered copies, and holds multiply/divide operations for a configurable number of cycles to meet timing. It returns the result to the granted requester with a one-cycle response pulse.

---
 rtl/alu_scheduler.sv | 203 ++++++++++++++++++++
 tb/tb_alu_scheduler.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// Shares one combinational ALU among NREQ requesters: accept, hold operands for L cycles, return result.
// Define ALU_SCHED_RR_EN for round-robin arbitration; otherwise lowest index wins.
module alu_scheduler #(
  parameter int NREQ       = 2,
  parameter int MULDIV_LAT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [4*NREQ-1:0]    req_ctl,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [3:0]           alu_ctl,
  input  logic [31:0]          alu_c,
  output logic [NREQ-1:0]      resp_valid,
  output logic [31:0]          resp_data,
  output logic                 resp_err,
  output logic                 busy
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [IDXW-1:0]   grant_idx_s;
  logic              grant_found_s;
  logic [IDXW-1:0]   grant_r;
  logic [3:0]        cnt_r;
  logic [3:0]        lat_m1_s;
  logic              accept_s;
  logic              last_exec_s;
  logic [31:0]       sel_a_s;
  logic [31:0]       sel_b_s;
  logic [3:0]        sel_ctl_s;
  logic [31:0]       res_data_s;
  logic              res_err_s;
  logic [31:0]       alu_a_r;
  logic [31:0]       alu_b_r;
  logic [3:0]        alu_ctl_r;
  logic [NREQ-1:0]   resp_valid_r;
  logic [31:0]       resp_data_r;
  logic              resp_err_r;
  logic              busy_r;

`ifdef ALU_SCHED_RR_EN
  logic [IDXW-1:0]   rr_ptr_r;

  // Round-robin search starting at the pointer, wrapping once around the requesters
  always_comb begin : rr_search
    int              idx_v;
    logic [NREQ-1:0] sh_v;
    logic            hit_v;
    grant_idx_s   = '0;
    grant_found_s = 1'b0;
    idx_v         = 0;
    sh_v          = '0;
    hit_v         = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx_v = ((int'(rr_ptr_r) + k) >= NREQ) ? (int'(rr_ptr_r) + k - NREQ) : (int'(rr_ptr_r) + k);
      sh_v  = req_valid >> idx_v;
      hit_v = sh_v[0] & ~grant_found_s;
      grant_idx_s   = hit_v ? IDXW'(idx_v) : grant_idx_s;
      grant_found_s = grant_found_s | hit_v;
    end
  end

  // Pointer moves just past the requester that was accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= '0;
    end else if (accept_s) begin
      rr_ptr_r <= (grant_idx_s == IDXW'(NREQ - 1)) ? '0 : (grant_idx_s + IDXW'(1));
    end
  end
`else
  // Fixed priority: scan downward so the lowest valid index is the last to win
  always_comb begin : fixed_search
    logic [NREQ-1:0] sh_v;
    grant_idx_s   = '0;
    grant_found_s = 1'b0;
    sh_v          = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sh_v          = req_valid >> k;
      grant_idx_s   = sh_v[0] ? IDXW'(k) : grant_idx_s;
      grant_found_s = grant_found_s | sh_v[0];
    end
  end
`endif

  assign accept_s    = (state_r == IDLE) && grant_found_s;
  assign last_exec_s = (state_r == EXEC) && (cnt_r == 4'd0);
  assign sel_a_s     = req_a[32*grant_idx_s +: 32];
  assign sel_b_s     = req_b[32*grant_idx_s +: 32];
  assign sel_ctl_s   = req_ctl[4*grant_idx_s +: 4];
  assign lat_m1_s    = ((sel_ctl_s == 4'd2) || (sel_ctl_s == 4'd3)) ? 4'(MULDIV_LAT - 1) : 4'd0;

  // One-hot accept strobe, only while idle
  always_comb begin
    req_ready = '0;
    if (accept_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Result qualification: illegal opcodes and divide-by-zero override the ALU
  always_comb begin
    res_data_s = alu_c;
    res_err_s  = 1'b0;
    if (alu_ctl_r >= 4'd12) begin
      res_data_s = 32'h0000_0000;
      res_err_s  = 1'b1;
    end else if ((alu_ctl_r == 4'd3) && (alu_b_r == 32'h0000_0000)) begin
      res_data_s = 32'hFFFF_FFFF;
      res_err_s  = 1'b1;
    end else begin
      res_data_s = alu_c;
      res_err_s  = 1'b0;
    end
  end

  // Next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_found_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        if (cnt_r == 4'd0) begin
          state_next_s = RESP;
        end else begin
          state_next_s = EXEC;
        end
      end
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Operand capture, latency counter and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a_r      <= 32'h0000_0000;
      alu_b_r      <= 32'h0000_0000;
      alu_ctl_r    <= 4'd0;
      grant_r      <= '0;
      cnt_r        <= 4'd0;
      resp_valid_r <= '0;
      resp_data_r  <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      busy_r       <= (state_next_s != IDLE);
      resp_valid_r <= '0;
      if (accept_s) begin
        alu_a_r   <= sel_a_s;
        alu_b_r   <= sel_b_s;
        alu_ctl_r <= sel_ctl_s;
        grant_r   <= grant_idx_s;
        cnt_r     <= lat_m1_s;
      end else if (last_exec_s) begin
        resp_data_r  <= res_data_s;
        resp_err_r   <= res_err_s;
        resp_valid_r <= {{(NREQ-1){1'b0}}, 1'b1} << grant_r;
      end else if (state_r == EXEC) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  assign alu_a      = alu_a_r;
  assign alu_b      = alu_b_r;
  assign alu_ctl    = alu_ctl_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_scheduler.sv
// Directed bench for alu_scheduler with a small behavioural ALU in the loop.
module tb_alu_scheduler;

  localparam int NREQ       = 2;
  localparam int MULDIV_LAT = 4;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [32*NREQ-1:0]  req_a;
  logic [32*NREQ-1:0]  req_b;
  logic [4*NREQ-1:0]   req_ctl;
  logic [31:0]         alu_a;
  logic [31:0]         alu_b;
  logic [3:0]          alu_ctl;
  logic [31:0]         alu_c;
  logic [NREQ-1:0]     resp_valid;
  logic [31:0]         resp_data;
  logic                resp_err;
  logic                busy;

  int checks = 0;
  int errors = 0;

  alu_scheduler #(.NREQ(NREQ), .MULDIV_LAT(MULDIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctl(req_ctl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_c(alu_c),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; its divide-by-zero value differs from the scheduler's override
  always_comb begin
    case (alu_ctl)
      4'd0:    alu_c = alu_a + alu_b;
      4'd1:    alu_c = alu_a - alu_b;
      4'd2:    alu_c = alu_a * alu_b;
      4'd3:    alu_c = (alu_b == 32'd0) ? 32'h0BAD_0BAD : (alu_a / alu_b);
      4'd4:    alu_c = alu_a & alu_b;
      4'd5:    alu_c = alu_a | alu_b;
      default: alu_c = alu_a ^ alu_b;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] ctl, input int lat,
                       input logic [31:0] exp_d, input logic exp_e);
    logic [NREQ-1:0] oh;
    oh = 2'b01 << idx;
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
    req_ctl[4*idx +: 4] = ctl;
    req_valid = oh;
    #1;
    check("ready_at_accept", 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, b);
    check("alu_ctl", 32'(alu_ctl), 32'(ctl));
    check("busy_exec", 32'(busy), 32'd1);
    check("no_early_resp", 32'(resp_valid), 32'd0);
    for (int c = 1; c < lat; c++) begin
      step();
      check("no_early_resp", 32'(resp_valid), 32'd0);
    end
    step();
    check("resp_valid", 32'(resp_valid), 32'(oh));
    check("resp_data", resp_data, exp_d);
    check("resp_err", 32'(resp_err), 32'(exp_e));
    check("busy_resp", 32'(busy), 32'd1);
    step();
    check("resp_done", 32'(resp_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int              g;
    logic [NREQ-1:0] exp_oh;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_ctl   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    check("rst_alu_ctl", 32'(alu_ctl), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b1;
    step();

    do_op(0, 32'd5,   32'd7, 4'd0,  1,          32'd12,        1'b0);
    do_op(0, 32'd6,   32'd7, 4'd2,  MULDIV_LAT, 32'd42,        1'b0);
    do_op(1, 32'd100, 32'd0, 4'd3,  MULDIV_LAT, 32'hFFFF_FFFF, 1'b1);
    do_op(1, 32'd100, 32'd7, 4'd3,  MULDIV_LAT, 32'd14,        1'b0);
    do_op(1, 32'd9,   32'd4, 4'd13, 1,          32'd0,         1'b1);
    do_op(0, 32'd3,   32'd5, 4'd1,  1,          32'hFFFF_FFFE, 1'b0);

    // Withdrawn request: no accept, no response
    req_a[63:32] = 32'd1;
    req_b[63:32] = 32'd2;
    req_ctl[7:4] = 4'd0;
    req_valid    = 2'b10;
    #1;
    check("withdraw_ready", 32'(req_ready), 32'd2);
    req_valid = 2'b00;
    step();
    check("withdraw_busy", 32'(busy), 32'd0);
    step();
    check("withdraw_resp", 32'(resp_valid), 32'd0);

    // Async reset in the middle of a multiply
    req_a[63:32] = 32'd3;
    req_b[63:32] = 32'd3;
    req_ctl[7:4] = 4'd2;
    req_valid    = 2'b10;
    #1;
    step();
    req_valid = 2'b00;
    check("mid_busy", 32'(busy), 32'd1);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_ctl", 32'(alu_ctl), 32'd0);
    check("mid_rst_resp_data", resp_data, 32'd0);
    check("mid_rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      check("post_rst_no_resp", 32'(resp_valid), 32'd0);
    end

    // Contention: both requesters held valid
    req_a   = {32'd2, 32'd1};
    req_b   = {32'd2, 32'd1};
    req_ctl = {4'd0, 4'd0};
    req_valid = 2'b11;
    #1;
    for (int n = 0; n < 4; n++) begin
`ifdef ALU_SCHED_RR_EN
      g = n % 2;
`else
      g = 0;
`endif
      exp_oh = 2'b01 << g;
      check("cont_grant", 32'(req_ready), 32'(exp_oh));
      step();
      check("cont_ready_exec", 32'(req_ready), 32'd0);
      step();
      check("cont_resp_valid", 32'(resp_valid), 32'(exp_oh));
      check("cont_resp_data", resp_data, (g == 1) ? 32'd4 : 32'd2);
      step();
      check("cont_idle", 32'(busy), 32'd0);
    end
    req_valid = 2'b00;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
